// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a universal shift register: accepts LOAD/SHL/SHR/ROL/ROR/CLR commands,
// drives the register pins for the required number of cycles, and streams out the shifted-out bits.
module shift_seq_ctrl #(
   parameter int N     = 8,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [N-1:0]     cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             ser_in,
   input  logic [N-1:0]     reg_q,
   output logic [1:0]       reg_sel,
   output logic [N-1:0]     reg_in,
   output logic             reg_left_in,
   output logic             reg_right_in,
   output logic             reg_clear,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             ser_out,
   output logic             ser_out_valid
);

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_SHL  = 3'b001;
   localparam logic [2:0] OP_SHR  = 3'b010;
   localparam logic [2:0] OP_ROL  = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;
   localparam logic [2:0] OP_CLR  = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [N-1:0]       data_q, data_d;
   logic [CNT_W-1:0]   rem_q, rem_d;

   // Only the end bits of the register feed back; the middle bits are deliberately ignored.
   logic               unused_reg_q_mid;
   assign unused_reg_q_mid = ^reg_q[N-2:1];

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         data_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      data_d        = data_q;
      rem_d         = rem_q;
      cmd_ready     = 1'b0;
      reg_sel       = 2'b00;
      reg_in        = '0;
      reg_left_in   = 1'b0;
      reg_right_in  = 1'b0;
      reg_clear     = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      err           = 1'b0;
      ser_out       = 1'b0;
      ser_out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready = clear_n;
            if (cmd_valid && cmd_ready) begin
               op_d   = cmd_op;
               data_d = cmd_data;
               case (cmd_op)
                  OP_LOAD, OP_CLR:                rem_d = CNT_W'(1);
                  OP_SHL, OP_SHR, OP_ROL, OP_ROR: rem_d = cmd_count;
                  default:                        rem_d = '0;
               endcase
               state_d = (rem_d != '0) ? EXEC : DONE;
            end
         end
         EXEC: begin
            busy  = 1'b1;
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_d = DONE;
            case (op_q)
               OP_LOAD: begin
                  reg_sel = 2'b01;
                  reg_in  = data_q;
               end
               OP_CLR: reg_clear = 1'b1;
               OP_SHL: begin
                  reg_sel       = 2'b10;
                  reg_right_in  = ser_in;
                  ser_out       = reg_q[N-1];
                  ser_out_valid = 1'b1;
               end
               OP_ROL: begin
                  reg_sel       = 2'b10;
                  reg_right_in  = reg_q[N-1];
                  ser_out       = reg_q[N-1];
                  ser_out_valid = 1'b1;
               end
               OP_SHR: begin
                  reg_sel       = 2'b11;
                  reg_left_in   = ser_in;
                  ser_out       = reg_q[0];
                  ser_out_valid = 1'b1;
               end
               OP_ROR: begin
                  reg_sel       = 2'b11;
                  reg_left_in   = reg_q[0];
                  ser_out       = reg_q[0];
                  ser_out_valid = 1'b1;
               end
               default: ;
            endcase
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            err     = (op_q[2:1] == 2'b11);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural universal shift register closing the loop.
module tb_shift_seq_ctrl;

   localparam int N     = 8;
   localparam int CNT_W = 4;

   logic             clock = 1'b0;
   logic             clear_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [N-1:0]     cmd_data;
   logic [CNT_W-1:0] cmd_count;
   logic             ser_in;
   logic [N-1:0]     reg_q;
   logic [1:0]       reg_sel;
   logic [N-1:0]     reg_in;
   logic             reg_left_in, reg_right_in, reg_clear;
   logic             busy, done, err, ser_out, ser_out_valid;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   shift_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
      .clock(clock), .clear_n(clear_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
      .ser_in(ser_in), .reg_q(reg_q),
      .reg_sel(reg_sel), .reg_in(reg_in),
      .reg_left_in(reg_left_in), .reg_right_in(reg_right_in), .reg_clear(reg_clear),
      .busy(busy), .done(done), .err(err),
      .ser_out(ser_out), .ser_out_valid(ser_out_valid)
   );

   // Controlled register: not reset by clear_n, keeps whatever it last captured.
   logic [N-1:0] sr = '0;
   assign reg_q = sr;
   always @(posedge clock) begin
      if (reg_clear) sr <= '0;
      else case (reg_sel)
         2'b01:   sr <= reg_in;
         2'b10:   sr <= {sr[N-2:0], reg_right_in};
         2'b11:   sr <= {reg_left_in, sr[N-1:1]};
         default: sr <= sr;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  data;
      logic [3:0]  cnt;
      logic        ser;
      int          k;
      logic [1:0]  sel;
      logic        sv;
      logic [15:0] bits;
      logic [7:0]  q;
      logic        er;
   } vec_t;

   vec_t tv[9];

   initial begin
      tv[0] = '{3'b000, 8'hA5, 4'd0,  1'b0, 1, 2'b01, 1'b0, 16'h0000, 8'hA5, 1'b0};
      tv[1] = '{3'b001, 8'h00, 4'd3,  1'b1, 3, 2'b10, 1'b1, 16'h0005, 8'h2F, 1'b0};
      tv[2] = '{3'b100, 8'h00, 4'd4,  1'b0, 4, 2'b11, 1'b1, 16'h000F, 8'hF2, 1'b0};
      tv[3] = '{3'b011, 8'h00, 4'd8,  1'b0, 8, 2'b10, 1'b1, 16'h004F, 8'hF2, 1'b0};
      tv[4] = '{3'b001, 8'h00, 4'd0,  1'b1, 0, 2'b00, 1'b0, 16'h0000, 8'hF2, 1'b0};
      tv[5] = '{3'b110, 8'h33, 4'd5,  1'b0, 0, 2'b00, 1'b0, 16'h0000, 8'hF2, 1'b1};
      tv[6] = '{3'b010, 8'h00, 4'd2,  1'b1, 2, 2'b11, 1'b1, 16'h0002, 8'hFC, 1'b0};
      tv[7] = '{3'b000, 8'hF2, 4'd0,  1'b0, 1, 2'b01, 1'b0, 16'h0000, 8'hF2, 1'b0};
      tv[8] = '{3'b111, 8'h00, 4'd9,  1'b0, 0, 2'b00, 1'b0, 16'h0000, 8'hF2, 1'b1};

      clear_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_count = '0; ser_in = 1'b0;
      #3;
      chk("rst_ready", cmd_ready, 0);
      chk("rst_outs", {reg_sel, reg_in, reg_left_in, reg_right_in, reg_clear, busy, done, err,
                       ser_out, ser_out_valid}, 0);
      @(negedge clock); @(negedge clock);
      clear_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 9; i++) begin
         chk($sformatf("v%0d_ready", i), cmd_ready, 1);
         cmd_valid = 1'b1; cmd_op = tv[i].op; cmd_data = tv[i].data;
         cmd_count = tv[i].cnt; ser_in = tv[i].ser;
         @(negedge clock);
         cmd_valid = 1'b0;
         for (int c = 0; c < tv[i].k; c++) begin
            chk($sformatf("v%0d_c%0d_sel", i, c), reg_sel, tv[i].sel);
            chk($sformatf("v%0d_c%0d_busy_rdy", i, c), {busy, cmd_ready, done}, 3'b100);
            chk($sformatf("v%0d_c%0d_sov", i, c), ser_out_valid, tv[i].sv);
            chk($sformatf("v%0d_c%0d_in", i, c), reg_in, (tv[i].op == 3'b000) ? tv[i].data : 8'h00);
            if (tv[i].sv)
               chk($sformatf("v%0d_c%0d_ser", i, c), ser_out, tv[i].bits[c]);
            @(negedge clock);
         end
         chk($sformatf("v%0d_done", i), {done, err, cmd_ready, busy}, {1'b1, tv[i].er, 1'b0, 1'b1});
         chk($sformatf("v%0d_done_sel", i), {reg_sel, ser_out_valid}, 0);
         @(negedge clock);
         chk($sformatf("v%0d_idle", i), {done, err, cmd_ready, busy}, 4'b0010);
         chk($sformatf("v%0d_q", i), reg_q, tv[i].q);
      end

      // Reset during the third shift of a long SHR.
      cmd_valid = 1'b1; cmd_op = 3'b010; cmd_count = 4'd10; ser_in = 1'b0;
      @(negedge clock);
      cmd_valid = 1'b0;
      chk("mid_c1_sel", reg_sel, 2'b11);
      @(negedge clock);
      chk("mid_c2_sel", reg_sel, 2'b11);
      @(posedge clock);
      #2 clear_n = 1'b0;
      #1;
      chk("mid_rst_sel", reg_sel, 2'b00);
      chk("mid_rst_flags", {busy, done, cmd_ready, ser_out_valid}, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         chk($sformatf("mid_no_done%0d", c), done, 0);
      end
      clear_n = 1'b1;
      @(negedge clock);
      chk("mid_q", reg_q, 8'h3C);
      chk("mid_ready", {cmd_ready, done}, 2'b10);

      // cmd_valid held across a CLR so the following LOAD waits for IDLE.
      cmd_valid = 1'b1; cmd_op = 3'b101; cmd_data = 8'h00;
      @(negedge clock);
      chk("clr_exec", {reg_clear, reg_sel, cmd_ready}, 4'b1000);
      cmd_op = 3'b000; cmd_data = 8'h5A;
      @(negedge clock);
      chk("clr_done", {done, err, cmd_ready, reg_clear}, 4'b1000);
      @(negedge clock);
      chk("clr_q", reg_q, 8'h00);
      chk("clr_ready", cmd_ready, 1);
      @(negedge clock);
      cmd_valid = 1'b0;
      chk("ld_exec", {reg_sel, reg_in}, {2'b01, 8'h5A});
      @(negedge clock);
      chk("ld_done", {done, err}, 2'b10);
      @(negedge clock);
      chk("ld_q", reg_q, 8'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
